// File: rtl/popcount_pipe.sv
// Pipelined valid/ready popcount with a saturating per-frame accumulator.
// Optional define POPCOUNT_PIPE_MASK_EN adds mask_i; the unit then counts data_i & mask_i.
module popcount_pipe #(
  parameter int INPUT_WIDTH = 256,
  parameter int STAGES      = 2,
  parameter int ACC_WIDTH   = 16,
  localparam int POPCOUNT_WIDTH = $clog2(INPUT_WIDTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [INPUT_WIDTH-1:0]    data_i,
`ifdef POPCOUNT_PIPE_MASK_EN
  input  logic [INPUT_WIDTH-1:0]    mask_i,
`endif
  input  logic                      last_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [POPCOUNT_WIDTH-1:0] popcount_o,
  output logic [ACC_WIDTH-1:0]      acc_o,
  output logic                      acc_ovf_o,
  output logic                      last_o
);

  localparam int PCW   = POPCOUNT_WIDTH;
  localparam int LVLS  = POPCOUNT_WIDTH - 1;
  localparam int PAD_W = 1 << LVLS;
  localparam int STG_W = (STAGES > 0) ? STAGES : 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  if (INPUT_WIDTH < 2) begin : g_err_width
    $error("popcount_pipe: INPUT_WIDTH must be >= 2");
  end
  if (STAGES < 0 || STAGES > LVLS) begin : g_err_stages
    $error("popcount_pipe: STAGES must be in 0..$clog2(INPUT_WIDTH)");
  end
  if (ACC_WIDTH < POPCOUNT_WIDTH) begin : g_err_acc
    $error("popcount_pipe: ACC_WIDTH must be >= POPCOUNT_WIDTH");
  end

  // Stage s (1-based) registers the output of tree level floor(s*LVLS/STAGES); 0 = no register.
  function automatic int stage_idx(input int lvl);
    int r;
    r = 0;
    for (int s = 1; s <= STAGES; s++) begin
      if ((s * LVLS) / STG_W == lvl) r = s;
    end
    return r;
  endfunction

  logic [INPUT_WIDTH-1:0] bits_s;
  logic [PCW-1:0]         src_s [0:LVLS][0:PAD_W-1];
  logic [STG_W-1:0]       en_s;

`ifdef POPCOUNT_PIPE_MASK_EN
  assign bits_s = data_i & mask_i;
`else
  assign bits_s = data_i;
`endif

  for (genvar i = 0; i < PAD_W; i++) begin : g_leaf
    if (i < INPUT_WIDTH) begin : g_bit
      assign src_s[0][i] = PCW'(bits_s[i]);
    end else begin : g_pad
      assign src_s[0][i] = '0;
    end
  end

  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int N  = PAD_W >> k;
    localparam int SI = stage_idx(k);
    logic [PCW-1:0] sum_s [0:N-1];
    for (genvar j = 0; j < N; j++) begin : g_add
      assign sum_s[j] = src_s[k-1][2*j] + src_s[k-1][2*j+1];
    end
    if (SI > 0) begin : g_reg
      logic [PCW-1:0] node_q [0:N-1];
      // tree level register, advances with its stage
      always_ff @(posedge clk_i) begin
        if (en_s[SI-1]) node_q <= sum_s;
      end
      for (genvar j = 0; j < N; j++) begin : g_out
        assign src_s[k][j] = node_q[j];
      end
    end else begin : g_wire
      for (genvar j = 0; j < N; j++) begin : g_out
        assign src_s[k][j] = sum_s[j];
      end
    end
    for (genvar j = N; j < PAD_W; j++) begin : g_unused
      assign src_s[k][j] = '0;
    end
  end

  assign popcount_o = src_s[LVLS][0];

  if (STAGES == 0) begin : g_comb
    assign ready_o = ready_i;
    assign valid_o = valid_i;
    assign last_o  = last_i;
    assign en_s    = '0;
  end else begin : g_pipe
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] last_q;
    logic [STAGES-1:0] v_up_s;
    logic [STAGES-1:0] l_up_s;

    assign v_up_s = (v_q << 1) | STAGES'(valid_i);
    assign l_up_s = (last_q << 1) | STAGES'(last_i);

    // a stage may load when it, or any stage after it, has room or the output drains
    always_comb begin
      logic run;
      run  = ready_i;
      en_s = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        run     = run | ~v_q[s];
        en_s[s] = run;
      end
    end

    // per-stage valid bits
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v_q <= '0;
      end else begin
        v_q <= (v_q & ~en_s) | (v_up_s & en_s);
      end
    end

    // last flag travels with its beat
    always_ff @(posedge clk_i) begin
      last_q <= (last_q & ~en_s) | (l_up_s & en_s);
    end

    assign ready_o = en_s[0];
    assign valid_o = v_q[STAGES-1];
    assign last_o  = last_q[STAGES-1];
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum_s;

  assign sum_s = {1'b0, acc_q} + (ACC_WIDTH + 1)'(popcount_o);

  // saturating frame sum seen with the current output beat
  always_comb begin
    acc_o     = sum_s[ACC_WIDTH] ? ACC_MAX : sum_s[ACC_WIDTH-1:0];
    acc_ovf_o = ovf_q | sum_s[ACC_WIDTH];
  end

  // frame state advances on an output handshake and restarts after the last beat
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (valid_o && ready_i) begin
      if (last_o) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_o;
        ovf_d = acc_ovf_o;
      end
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end
  end

  // accumulator registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
